control_sequencer: RTL and testbench
====================================

# control_sequencer

Fetch/decode/execute controller for the SAP-1.5 computer. It steps the shared 8-bit bus datapath (PC, MAR, RAM, IR, A, B, ALU, flags, output register) through a variable-length micro-step sequence per instruction. Each step drives exactly one bus source and the matching load strobes, decoded from the current step and the IR opcode. It sits inside `computer` between the instruction register and every datapath enable.

## Interface
Parameters:
- `OPCODE_W`, default 4: opcode width (IR[7:4]).

Ports:
- `clk`, input, 1: system clock; all state changes on the rising edge.
- `reset`, input, 1: asynchronous, active-low reset.
- `opcode`, input, OPCODE_W: IR upper nibble; valid from step E0 onward.
- `flag_carry`, input, 1: registered carry flag from the flags register.
- `flag_zero`, input, 1: registered zero flag from the flags register.
- `pc_inc`, output, 1: PC increments at the next edge.
- `pc_oe`, output, 1: PC drives the bus.
- `pc_load`, output, 1: PC loads from the bus.
- `mar_load`, output, 1: MAR loads the bus low nibble.
- `ram_oe`, output, 1: RAM[MAR] drives the bus.
- `ram_we`, output, 1: RAM[MAR] is written from the bus.
- `ir_load`, output, 1: IR loads from the bus.
- `ir_oe`, output, 1: IR operand (low nibble, zero-extended) drives the bus.
- `a_load`, output, 1: register A load.
- `a_oe`, output, 1: register A output enable.
- `b_load`, output, 1: register B load.
- `alu_oe`, output, 1: ALU result drives the bus.
- `alu_sub`, output, 1: ALU computes A−B instead of A+B.
- `flags_load`, output, 1: flags capture the ALU carry/zero.
- `out_load`, output, 1: output register loads from the bus.
- `halt`, output, 1: sequencer is halted.
- `step`, output, 3: current step encoding, for debug.

## Operation
- Steps and encodings: T0=0, T1=1, E0=2, E1=3, E2=4, HALT=7. Codes 5 and 6 are unused and recover to T0.
- T0: `pc_oe`, `mar_load`. Next step is T1.
- T1: `ram_oe`, `ir_load`, `pc_inc`. Next step is E0.
- Execute steps per opcode. Each instruction returns to T0 after its last listed step.
  - 0 NOP: E0 idle.
  - 1 LDA: E0 `ir_oe`+`mar_load`; E1 `ram_oe`+`a_load`.
  - 2 LDB: E0 `ir_oe`+`mar_load`; E1 `ram_oe`+`b_load`.
  - 3 ADD: E0 `ir_oe`+`mar_load`; E1 `ram_oe`+`b_load`; E2 `alu_oe`+`a_load`+`flags_load`.
  - 4 SUB: same as ADD, with `alu_sub` also asserted in E2.
  - 5 STA: E0 `ir_oe`+`mar_load`; E1 `a_oe`+`ram_we`.
  - 6 LDI: E0 `ir_oe`+`a_load`.
  - 7 JMP: E0 `ir_oe`+`pc_load`.
  - 8 JC: E0 `ir_oe`+`pc_load` only if `flag_carry`=1, otherwise idle.
  - 9 JZ: E0 `ir_oe`+`pc_load` only if `flag_zero`=1, otherwise idle.
  - E OUT: E0 `a_oe`+`out_load`.
  - F HLT: E0 idle, next step is HALT.
  - A–D: treated as NOP.
- HALT: all strobes are 0 and `halt`=1. The sequencer stays in HALT until reset.
- Control outputs are combinational from `step`, `opcode` and the flags. At most one `*_oe` is high in any step.
- The flags are sampled during E0 of JC/JZ. Flag values written by the immediately preceding ADD/SUB E2 are visible there.

## Timing
- Reset asserted (low), at any time including mid-instruction:
  - `step` goes to T0 immediately.
  - All control outputs are forced to 0 and `halt`=0.
- First rising edge after reset release performs the T0 transfer.
- Instruction lengths in cycles: NOP/LDI/JMP/JC/JZ/OUT = 3, LDA/LDB/STA = 4, ADD/SUB = 5, HLT = 3 and then parked.
- PC has advanced past the instruction by the end of T1. A taken jump overrides it in E0.
- Strobes are single-cycle. No output holds across two steps except in HALT.
- No handshake: every step lasts exactly one `clk` cycle.

## Configuration
- `COND_JUMP_EN` defined: JC (8) and JZ (9) behave as described above.
- `COND_JUMP_EN` undefined:
  - Opcodes 8 and 9 execute as 3-cycle NOPs.
  - `flag_carry` and `flag_zero` are ignored.
  - Unconditional JMP is unaffected.

## Test plan
- Program LDA 0xE, RAM[0xE]=0x44, released from reset → `a_load` with `ram_oe` in cycle 4; A=0x44 after 4 cycles. `step` sequence 0,1,2,3,0.
- LDI 0x5; LDB 0xF (RAM[0xF]=0x22); ADD 0xF → B=0x22 at cycle 7. A=0x27 after the ADD E2 edge (cycle 12). `flags_load` pulses once.
- SUB with A=0x03, B=0x03 followed by JZ 0x0 → `flag_zero`=1 and `pc_load` asserted in JZ E0. With `COND_JUMP_EN` undefined, `pc_load` stays 0.
- JC with `flag_carry`=0 → no `pc_load`, and the instruction takes 3 cycles. With `flag_carry`=1, `ir_oe`+`pc_load` assert in E0.
- OUT then HLT → `out_load` pulses once and `halt`=1 from the cycle after HLT E0. `halt` holds for 100 cycles with all strobes 0.
- Reset pulled low during ADD E1 → `step`=0 and strobes=0 asynchronously. After release the fetch restarts at T0 with no B/A load from the aborted instruction.

Source files
------------

// File: rtl/control_sequencer.sv
// control_sequencer: SAP-1.5 fetch/decode/execute micro-step controller.
// Latency: control strobes are combinational from step/opcode/flags; step advances every clk edge.
// Backpressure: none, every micro-step lasts exactly one clk cycle.
//
// Ports:
//   clk, reset (async, active-low)     clock and reset
//   opcode [OPCODE_W-1:0]              IR upper nibble, valid from E0 onward
//   flag_carry, flag_zero              registered ALU flags, sampled in E0 of JC/JZ
//   pc_*/mar_load/ram_*/ir_*/a_*/b_load/alu_*/flags_load/out_load  datapath strobes
//   halt                               sequencer parked in HALT
//   step [2:0]                         current step (T0=0 T1=1 E0=2 E1=3 E2=4 HALT=7)
//
// Build option: define COND_JUMP_EN to enable JC/JZ; otherwise opcodes 8/9 run as NOPs.

module control_sequencer #(
    parameter int OPCODE_W = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                flag_carry,
    input  logic                flag_zero,
    output logic                pc_inc,
    output logic                pc_oe,
    output logic                pc_load,
    output logic                mar_load,
    output logic                ram_oe,
    output logic                ram_we,
    output logic                ir_load,
    output logic                ir_oe,
    output logic                a_load,
    output logic                a_oe,
    output logic                b_load,
    output logic                alu_oe,
    output logic                alu_sub,
    output logic                flags_load,
    output logic                out_load,
    output logic                halt,
    output logic [2:0]          step
);

    typedef enum logic [2:0] {
        ST_T0   = 3'd0,
        ST_T1   = 3'd1,
        ST_E0   = 3'd2,
        ST_E1   = 3'd3,
        ST_E2   = 3'd4,
        ST_HALT = 3'd7
    } step_e;

    localparam logic [OPCODE_W-1:0] OP_LDA = OPCODE_W'(4'h1);
    localparam logic [OPCODE_W-1:0] OP_LDB = OPCODE_W'(4'h2);
    localparam logic [OPCODE_W-1:0] OP_ADD = OPCODE_W'(4'h3);
    localparam logic [OPCODE_W-1:0] OP_SUB = OPCODE_W'(4'h4);
    localparam logic [OPCODE_W-1:0] OP_STA = OPCODE_W'(4'h5);
    localparam logic [OPCODE_W-1:0] OP_LDI = OPCODE_W'(4'h6);
    localparam logic [OPCODE_W-1:0] OP_JMP = OPCODE_W'(4'h7);
    localparam logic [OPCODE_W-1:0] OP_JC  = OPCODE_W'(4'h8);
    localparam logic [OPCODE_W-1:0] OP_JZ  = OPCODE_W'(4'h9);
    localparam logic [OPCODE_W-1:0] OP_OUT = OPCODE_W'(4'hE);
    localparam logic [OPCODE_W-1:0] OP_HLT = OPCODE_W'(4'hF);

    step_e step_q;
    step_e step_d;

    logic jc_take;
    logic jz_take;

`ifdef COND_JUMP_EN
    assign jc_take = flag_carry;
    assign jz_take = flag_zero;
`else
    // Conditional jumps compiled out: flags have no effect on sequencing.
    logic unused_flags;
    assign unused_flags = flag_carry | flag_zero;
    assign jc_take = 1'b0;
    assign jz_take = 1'b0;
`endif

    // Raw strobes before reset gating.
    logic pc_inc_c, pc_oe_c, pc_load_c, mar_load_c, ram_oe_c, ram_we_c;
    logic ir_load_c, ir_oe_c, a_load_c, a_oe_c, b_load_c, alu_oe_c;
    logic alu_sub_c, flags_load_c, out_load_c, halt_c;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            step_q <= ST_T0;
        end else begin
            step_q <= step_d;
        end
    end

    always_comb begin
        step_d       = ST_T0;
        pc_inc_c     = 1'b0;
        pc_oe_c      = 1'b0;
        pc_load_c    = 1'b0;
        mar_load_c   = 1'b0;
        ram_oe_c     = 1'b0;
        ram_we_c     = 1'b0;
        ir_load_c    = 1'b0;
        ir_oe_c      = 1'b0;
        a_load_c     = 1'b0;
        a_oe_c       = 1'b0;
        b_load_c     = 1'b0;
        alu_oe_c     = 1'b0;
        alu_sub_c    = 1'b0;
        flags_load_c = 1'b0;
        out_load_c   = 1'b0;
        halt_c       = 1'b0;

        case (step_q)
            ST_T0: begin
                pc_oe_c    = 1'b1;
                mar_load_c = 1'b1;
                step_d     = ST_T1;
            end
            ST_T1: begin
                ram_oe_c  = 1'b1;
                ir_load_c = 1'b1;
                pc_inc_c  = 1'b1;
                step_d    = ST_E0;
            end
            ST_E0: begin
                case (opcode)
                    OP_LDA, OP_LDB, OP_ADD, OP_SUB, OP_STA: begin
                        ir_oe_c    = 1'b1;
                        mar_load_c = 1'b1;
                        step_d     = ST_E1;
                    end
                    OP_LDI: begin
                        ir_oe_c  = 1'b1;
                        a_load_c = 1'b1;
                    end
                    OP_JMP: begin
                        ir_oe_c   = 1'b1;
                        pc_load_c = 1'b1;
                    end
                    OP_JC: begin
                        ir_oe_c   = jc_take;
                        pc_load_c = jc_take;
                    end
                    OP_JZ: begin
                        ir_oe_c   = jz_take;
                        pc_load_c = jz_take;
                    end
                    OP_OUT: begin
                        a_oe_c     = 1'b1;
                        out_load_c = 1'b1;
                    end
                    OP_HLT: step_d = ST_HALT;
                    default: ;  // NOP and unassigned opcodes idle for one step
                endcase
            end
            ST_E1: begin
                case (opcode)
                    OP_LDA: begin
                        ram_oe_c = 1'b1;
                        a_load_c = 1'b1;
                    end
                    OP_LDB: begin
                        ram_oe_c = 1'b1;
                        b_load_c = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        ram_oe_c = 1'b1;
                        b_load_c = 1'b1;
                        step_d   = ST_E2;
                    end
                    OP_STA: begin
                        a_oe_c   = 1'b1;
                        ram_we_c = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_E2: begin
                if (opcode == OP_ADD || opcode == OP_SUB) begin
                    alu_oe_c     = 1'b1;
                    a_load_c     = 1'b1;
                    flags_load_c = 1'b1;
                    alu_sub_c    = (opcode == OP_SUB);
                end
            end
            ST_HALT: begin
                halt_c = 1'b1;
                step_d = ST_HALT;
            end
            default: step_d = ST_T0;  // unused codes 5/6 fall back to fetch
        endcase
    end

    // While reset is held the step register already reads T0, but T0 would
    // drive pc_oe/mar_load, so every output is explicitly masked.
    assign pc_inc     = pc_inc_c     & reset;
    assign pc_oe      = pc_oe_c      & reset;
    assign pc_load    = pc_load_c    & reset;
    assign mar_load   = mar_load_c   & reset;
    assign ram_oe     = ram_oe_c     & reset;
    assign ram_we     = ram_we_c     & reset;
    assign ir_load    = ir_load_c    & reset;
    assign ir_oe      = ir_oe_c      & reset;
    assign a_load     = a_load_c     & reset;
    assign a_oe       = a_oe_c       & reset;
    assign b_load     = b_load_c     & reset;
    assign alu_oe     = alu_oe_c     & reset;
    assign alu_sub    = alu_sub_c    & reset;
    assign flags_load = flags_load_c & reset;
    assign out_load   = out_load_c   & reset;
    assign halt       = halt_c       & reset;
    assign step       = step_q;

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: directed + random instruction stream for control_sequencer.
// Latency: expected strobes come from a per-instruction table indexed by cycle number.
// Backpressure: not applicable, the sequencer free-runs one step per clock.

module tb_control_sequencer;

    localparam logic [15:0] PC_INC     = 16'h8000;
    localparam logic [15:0] PC_OE      = 16'h4000;
    localparam logic [15:0] PC_LOAD    = 16'h2000;
    localparam logic [15:0] MAR_LOAD   = 16'h1000;
    localparam logic [15:0] RAM_OE     = 16'h0800;
    localparam logic [15:0] RAM_WE     = 16'h0400;
    localparam logic [15:0] IR_LOAD    = 16'h0200;
    localparam logic [15:0] IR_OE      = 16'h0100;
    localparam logic [15:0] A_LOAD     = 16'h0080;
    localparam logic [15:0] A_OE       = 16'h0040;
    localparam logic [15:0] B_LOAD     = 16'h0020;
    localparam logic [15:0] ALU_OE     = 16'h0010;
    localparam logic [15:0] ALU_SUB    = 16'h0008;
    localparam logic [15:0] FLAGS_LOAD = 16'h0004;
    localparam logic [15:0] OUT_LOAD   = 16'h0002;
    localparam logic [15:0] HALT_BIT   = 16'h0001;

`ifdef COND_JUMP_EN
    localparam bit COND = 1'b1;
`else
    localparam bit COND = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] opcode;
    logic       flag_carry, flag_zero;
    logic       pc_inc, pc_oe, pc_load, mar_load, ram_oe, ram_we, ir_load, ir_oe;
    logic       a_load, a_oe, b_load, alu_oe, alu_sub, flags_load, out_load, halt;
    logic [2:0] step;
    logic [15:0] ctl;

    int n_cmp = 0;
    int n_err = 0;

    control_sequencer #(.OPCODE_W(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .flag_carry (flag_carry),
        .flag_zero  (flag_zero),
        .pc_inc     (pc_inc),
        .pc_oe      (pc_oe),
        .pc_load    (pc_load),
        .mar_load   (mar_load),
        .ram_oe     (ram_oe),
        .ram_we     (ram_we),
        .ir_load    (ir_load),
        .ir_oe      (ir_oe),
        .a_load     (a_load),
        .a_oe       (a_oe),
        .b_load     (b_load),
        .alu_oe     (alu_oe),
        .alu_sub    (alu_sub),
        .flags_load (flags_load),
        .out_load   (out_load),
        .halt       (halt),
        .step       (step)
    );

    always #5 clk = ~clk;

    assign ctl = {pc_inc, pc_oe, pc_load, mar_load, ram_oe, ram_we, ir_load, ir_oe,
                  a_load, a_oe, b_load, alu_oe, alu_sub, flags_load, out_load, halt};

    // Instruction length in cycles, fetch included.
    function automatic int instr_len(logic [3:0] op);
        case (op)
            4'h1, 4'h2, 4'h5: return 4;
            4'h3, 4'h4:       return 5;
            default:          return 3;
        endcase
    endfunction

    // Expected control word for cycle k (0 = T0) of instruction op.
    function automatic logic [15:0] exp_word(int k, logic [3:0] op, logic c, logic z);
        if (k == 0) return PC_OE | MAR_LOAD;
        if (k == 1) return RAM_OE | IR_LOAD | PC_INC;
        if (k == 2) begin
            case (op)
                4'h1, 4'h2, 4'h3, 4'h4, 4'h5: return IR_OE | MAR_LOAD;
                4'h6: return IR_OE | A_LOAD;
                4'h7: return IR_OE | PC_LOAD;
                4'h8: return (COND && c) ? (IR_OE | PC_LOAD) : 16'h0;
                4'h9: return (COND && z) ? (IR_OE | PC_LOAD) : 16'h0;
                4'hE: return A_OE | OUT_LOAD;
                default: return 16'h0;
            endcase
        end
        if (k == 3) begin
            case (op)
                4'h1:             return RAM_OE | A_LOAD;
                4'h2, 4'h3, 4'h4: return RAM_OE | B_LOAD;
                4'h5:             return A_OE | RAM_WE;
                default:          return 16'h0;
            endcase
        end
        if (op == 4'h4) return ALU_OE | A_LOAD | FLAGS_LOAD | ALU_SUB;
        if (op == 4'h3) return ALU_OE | A_LOAD | FLAGS_LOAD;
        return 16'h0;
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        n_cmp++;
        assert (obs === exp_v)
        else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic check_oe_onehot(input string tag);
        logic [15:0] ok;
        ok = {15'd0, ($countones({pc_oe, ram_oe, ir_oe, a_oe, alu_oe}) <= 1)};
        check(tag, ok, 16'h1);
    endtask

    // Runs cycles 0..maxk-1 of an instruction (whole instruction if maxk is larger).
    // Entered and left at posedge+1; opcode is garbage during fetch.
    task automatic run_instr(input logic [3:0] op, input logic c, input logic z,
                             input int maxk, input string tag);
        int n;
        n = instr_len(op);
        if (maxk < n) n = maxk;
        for (int k = 0; k < n; k++) begin
            opcode     = (k < 2) ? 4'($urandom_range(0, 15)) : op;
            flag_carry = c;
            flag_zero  = z;
            #1;
            check({tag, "_step"}, {13'd0, step}, 16'(k));
            check({tag, "_ctl"}, ctl, exp_word(k, op, c, z));
            check_oe_onehot({tag, "_oe1hot"});
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [3:0] op;
        logic       c, z;

        reset      = 1'b0;
        opcode     = 4'h3;
        flag_carry = 1'b1;
        flag_zero  = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            check("reset_step", {13'd0, step}, 16'h0);
            check("reset_ctl", ctl, 16'h0);
        end
        reset = 1'b1;

        // Directed program fragments.
        run_instr(4'h1, 1'b0, 1'b0, 99, "lda");
        run_instr(4'h6, 1'b0, 1'b0, 99, "ldi");
        run_instr(4'h2, 1'b0, 1'b0, 99, "ldb");
        run_instr(4'h3, 1'b0, 1'b0, 99, "add");
        run_instr(4'h4, 1'b0, 1'b1, 99, "sub");
        run_instr(4'h9, 1'b0, 1'b1, 99, "jz_taken");
        run_instr(4'h9, 1'b1, 1'b0, 99, "jz_not");
        run_instr(4'h8, 1'b0, 1'b1, 99, "jc_not");
        run_instr(4'h8, 1'b1, 1'b0, 99, "jc_taken");
        run_instr(4'h5, 1'b1, 1'b1, 99, "sta");
        run_instr(4'h7, 1'b0, 1'b0, 99, "jmp");
        run_instr(4'h0, 1'b1, 1'b1, 99, "nop");
        run_instr(4'hA, 1'b0, 1'b0, 99, "op_a");
        run_instr(4'hD, 1'b1, 1'b1, 99, "op_d");
        run_instr(4'hE, 1'b0, 1'b0, 99, "out");

        // Random instruction stream, HLT excluded.
        for (int i = 0; i < 150; i++) begin
            op = 4'($urandom_range(0, 14));
            c  = 1'($urandom);
            z  = 1'($urandom);
            run_instr(op, c, z, 99, "rand");
        end

        // Reset asserted mid-cycle during ADD E1.
        run_instr(4'h3, 1'b0, 1'b0, 3, "abort_pre");
        check("abort_e1_step", {13'd0, step}, 16'h3);
        check("abort_e1_ctl", ctl, RAM_OE | B_LOAD);
        #2;
        reset = 1'b0;
        #1;
        check("abort_async_step", {13'd0, step}, 16'h0);
        check("abort_async_ctl", ctl, 16'h0);
        @(posedge clk);
        #1;
        check("abort_held_ctl", ctl, 16'h0);
        reset = 1'b1;
        run_instr(4'h6, 1'b0, 1'b0, 99, "restart");

        // Halt: 3-cycle HLT, then parked with only halt high.
        run_instr(4'hF, 1'b1, 1'b1, 99, "hlt");
        for (int i = 0; i < 100; i++) begin
            opcode     = 4'($urandom_range(0, 15));
            flag_carry = 1'($urandom);
            flag_zero  = 1'($urandom);
            #1;
            check("halt_step", {13'd0, step}, 16'h7);
            check("halt_ctl", ctl, HALT_BIT);
            @(posedge clk);
            #1;
        end

        // Reset is the only way out of HALT.
        reset = 1'b0;
        #1;
        check("unhalt_step", {13'd0, step}, 16'h0);
        check("unhalt_ctl", ctl, 16'h0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        run_instr(4'h1, 1'b0, 1'b0, 99, "post_halt");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
